// File: rtl/project2_processor_if.sv
// Instruction-fetch bus between the core and the external instruction memory.
// The core drives the byte-address PC; the memory returns the instruction
// word combinationally within the same cycle.
interface project2_processor_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] pcOut;
    logic [DBITS-1:0] instWord;

    modport master (
        output pcOut,
        input  instWord
    );

    modport slave (
        input  pcOut,
        output instWord
    );
endinterface

// File: rtl/project2_processor.sv
// Single-cycle 32-bit processor core: 16-entry register file, internal data
// memory and memory-mapped board I/O (HEX displays, LEDR, LEDG, KEY, SW).
// Every architectural update (PC, register, memory, I/O) happens on the
// same rising edge of CLOCK_50; all reads are combinational.
module project2_processor #(
    parameter int          DBITS     = 32,
    parameter logic [31:0] START_PC  = 32'h0000_0040,
    parameter logic [31:0] ADDR_HEX  = 32'hF000_0000,
    parameter logic [31:0] ADDR_LEDR = 32'hF000_0004,
    parameter logic [31:0] ADDR_LEDG = 32'hF000_0008,
    parameter logic [31:0] ADDR_KEY  = 32'hF000_0010,
    parameter logic [31:0] ADDR_SW   = 32'hF000_0014,
    parameter int          DMEMWORDS = 2048
) (
    input  logic                 CLOCK_50,
    input  logic                 FPGA_RESET_N,
    input  logic [9:0]           SW,
    input  logic [3:0]           KEY,
    output logic [9:0]           LEDR,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5,
    project2_processor_if.master imem_bus
);

    localparam int NREGS   = 16;
    localparam int DMEM_AW = $clog2(DMEMWORDS);

    localparam logic [3:0] OP1_BR   = 4'h0;
    localparam logic [3:0] OP1_SW   = 4'h8;
    localparam logic [3:0] OP1_LW   = 4'h9;
    localparam logic [3:0] OP1_JAL  = 4'hA;
    localparam logic [3:0] OP1_ALUI = 4'hB;
    localparam logic [3:0] OP1_ALUR = 4'hF;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // ALU: returns {write_valid, result}; undefined op2 codes suppress the write.
    function automatic logic [DBITS:0] alu_f(
        input logic [3:0]       op,
        input logic [DBITS-1:0] x,
        input logic [DBITS-1:0] y
    );
        logic [DBITS:0] res;
        res = {1'b1, {DBITS{1'b0}}};
        case (op)
            4'h0:    res[DBITS-1:0] = x + y;
            4'h1:    res[DBITS-1:0] = x - y;
            4'h2:    res[DBITS-1:0] = x & y;
            4'h3:    res[DBITS-1:0] = x | y;
            4'h4:    res[DBITS-1:0] = x ^ y;
            4'h5:    res[DBITS-1:0] = ~(x & y);
            4'h6:    res[DBITS-1:0] = ~(x | y);
            4'h7:    res[DBITS-1:0] = ~(x ^ y);
            default: res = {(DBITS + 1){1'b0}};
        endcase
        return res;
    endfunction

    // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] seg7_f(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_ZERO;
        endcase
        return seg;
    endfunction

    // Architectural state
    logic [DBITS-1:0] pc_r;
    logic [DBITS-1:0] rf_r [0:NREGS-1];
    logic [DBITS-1:0] dmem_r [0:DMEMWORDS-1];
    logic [DBITS-1:0] hex_r;
    logic [DBITS-1:0] ledr_r;
    logic [DBITS-1:0] ledg_r;
    logic [5:0][6:0]  hex_seg_r;

    // Decode and datapath signals
    logic [DBITS-1:0] inst_s;
    logic [3:0]       op2_s;
    logic [3:0]       op1_s;
    logic [15:0]      imm_s;
    logic [3:0]       a_s;
    logic [3:0]       b_s;
    logic [3:0]       c_s;
    logic [DBITS-1:0] sext_s;
    logic [DBITS-1:0] ra_s;
    logic [DBITS-1:0] rb_s;
    logic [DBITS-1:0] rc_s;
    logic [DBITS-1:0] pc_plus4_s;
    logic [DBITS-1:0] br_target_s;
    logic [DBITS-1:0] mem_addr_s;
    logic [DBITS-1:0] mem_rdata_s;
    logic [DMEM_AW-1:0] dmem_idx_s;
    logic             addr_io_s;
    logic [DBITS:0]   alu_res_s;
    logic [DBITS-1:0] next_pc_s;
    logic             rf_we_s;
    logic [3:0]       rf_wa_s;
    logic [DBITS-1:0] rf_wd_s;
    logic             st_en_s;
    logic             st_hex_s;
    logic             st_ledr_s;
    logic             st_ledg_s;
    logic             st_dmem_s;

    assign imem_bus.pcOut = pc_r;
    assign LEDR           = ledr_r[9:0];
    assign HEX0           = hex_seg_r[0];
    assign HEX1           = hex_seg_r[1];
    assign HEX2           = hex_seg_r[2];
    assign HEX3           = hex_seg_r[3];
    assign HEX4           = hex_seg_r[4];
    assign HEX5           = hex_seg_r[5];

    // Field extraction, register reads and address generation.
    // The SW base register is B (A supplies store data); all others use A.
    always_comb begin
        inst_s      = imem_bus.instWord;
        op2_s       = inst_s[31:28];
        op1_s       = inst_s[27:24];
        imm_s       = inst_s[23:8];
        a_s         = inst_s[7:4];
        b_s         = inst_s[3:0];
        c_s         = inst_s[11:8];
        sext_s      = {{(DBITS - 16){imm_s[15]}}, imm_s};
        ra_s        = rf_r[a_s];
        rb_s        = rf_r[b_s];
        rc_s        = rf_r[c_s];
        pc_plus4_s  = pc_r + 32'd4;
        br_target_s = pc_plus4_s + {sext_s[DBITS-3:0], 2'b00};
        if (op1_s == OP1_SW) begin
            mem_addr_s = rb_s + sext_s;
        end else begin
            mem_addr_s = ra_s + sext_s;
        end
        dmem_idx_s = mem_addr_s[DMEM_AW+1:2];
        addr_io_s  = (mem_addr_s == ADDR_HEX)  || (mem_addr_s == ADDR_LEDR) ||
                     (mem_addr_s == ADDR_LEDG) || (mem_addr_s == ADDR_KEY)  ||
                     (mem_addr_s == ADDR_SW);
    end

    // Load data mux: I/O registers by full-address match, otherwise data memory.
    always_comb begin
        mem_rdata_s = {DBITS{1'b0}};
        if (mem_addr_s == ADDR_HEX) begin
            mem_rdata_s = hex_r;
        end else if (mem_addr_s == ADDR_LEDR) begin
            mem_rdata_s = ledr_r;
        end else if (mem_addr_s == ADDR_LEDG) begin
            mem_rdata_s = ledg_r;
        end else if (mem_addr_s == ADDR_KEY) begin
            mem_rdata_s = {{(DBITS - 4){1'b0}}, KEY};
        end else if (mem_addr_s == ADDR_SW) begin
            mem_rdata_s = {{(DBITS - 10){1'b0}}, SW};
        end else begin
            mem_rdata_s = dmem_r[dmem_idx_s];
        end
    end

    // Instruction execute: next PC, register write-back and store enable.
    always_comb begin
        next_pc_s = pc_plus4_s;
        rf_we_s   = 1'b0;
        rf_wa_s   = b_s;
        rf_wd_s   = {DBITS{1'b0}};
        st_en_s   = 1'b0;
        alu_res_s = {(DBITS + 1){1'b0}};
        case (op1_s)
            OP1_ALUR: begin
                alu_res_s = alu_f(op2_s, ra_s, rc_s);
                rf_we_s   = alu_res_s[DBITS];
                rf_wd_s   = alu_res_s[DBITS-1:0];
            end
            OP1_ALUI: begin
                if (op2_s == 4'hF) begin
                    rf_we_s = 1'b1;
                    rf_wd_s = {imm_s, 16'h0000};
                end else begin
                    alu_res_s = alu_f(op2_s, ra_s, sext_s);
                    rf_we_s   = alu_res_s[DBITS];
                    rf_wd_s   = alu_res_s[DBITS-1:0];
                end
            end
            OP1_LW: begin
                rf_we_s = 1'b1;
                rf_wd_s = mem_rdata_s;
            end
            OP1_SW: begin
                st_en_s = 1'b1;
            end
            OP1_BR: begin
                case (op2_s)
                    4'h0: begin
                        if (ra_s == rb_s) begin
                            next_pc_s = br_target_s;
                        end else begin
                            next_pc_s = pc_plus4_s;
                        end
                    end
                    4'h1: begin
                        if (ra_s != rb_s) begin
                            next_pc_s = br_target_s;
                        end else begin
                            next_pc_s = pc_plus4_s;
                        end
                    end
                    4'hC:    next_pc_s = br_target_s;
                    default: next_pc_s = pc_plus4_s;
                endcase
            end
            OP1_JAL: begin
                rf_we_s   = 1'b1;
                rf_wd_s   = pc_plus4_s;
                next_pc_s = ra_s + {sext_s[DBITS-3:0], 2'b00};
            end
            default: begin
                next_pc_s = pc_plus4_s;
            end
        endcase
        st_hex_s  = st_en_s && (mem_addr_s == ADDR_HEX);
        st_ledr_s = st_en_s && (mem_addr_s == ADDR_LEDR);
        st_ledg_s = st_en_s && (mem_addr_s == ADDR_LEDG);
        st_dmem_s = st_en_s && !addr_io_s;
    end

    // Program counter.
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            pc_r <= START_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Register file: all entries clear on reset; r0 is an ordinary register.
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {DBITS{1'b0}};
            end
        end else if (rf_we_s) begin
            rf_r[rf_wa_s] <= rf_wd_s;
        end
    end

    // Stored I/O registers; stores to KEY/SW addresses have no target here.
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            hex_r  <= {DBITS{1'b0}};
            ledr_r <= {DBITS{1'b0}};
            ledg_r <= {DBITS{1'b0}};
        end else begin
            if (st_hex_s) begin
                hex_r <= ra_s;
            end
            if (st_ledr_s) begin
                ledr_r <= ra_s;
            end
            if (st_ledg_s) begin
                ledg_r <= ra_s;
            end
        end
    end

    // Segment outputs are decoded from the store data so HEX0..5 come straight from flops.
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            hex_seg_r <= {6{SEG_ZERO}};
        end else if (st_hex_s) begin
            for (int k = 0; k < 6; k++) begin
                hex_seg_r[k] <= seg7_f(ra_s[4*k +: 4]);
            end
        end
    end

    // Data memory: word-addressed, not reset; low address bits are ignored.
    always_ff @(posedge CLOCK_50) begin
        if (st_dmem_s) begin
            dmem_r[dmem_idx_s] <= ra_s;
        end
    end

endmodule

// File: tb/tb_project2_processor.sv
// Directed bench for project2_processor: small programs are loaded into a
// bench-side instruction memory, expected values are queued on a scoreboard
// as each step is set up and popped as the matching DUT value is sampled.
module tb_project2_processor;

    logic       CLOCK_50 = 1'b0;
    logic       FPGA_RESET_N;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    logic [31:0] imem [0:255];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [31:0] NOP   = 32'h0E00_0000;
    localparam logic [31:0] HALT  = 32'hC0FF_FF00;
    localparam logic [31:0] SEG_0 = 32'h0000_0040;
    localparam logic [31:0] SEG_F = 32'h0000_000E;

    project2_processor_if bus ();
    assign bus.instWord = imem[bus.pcOut[9:2]];

    project2_processor dut (
        .CLOCK_50     (CLOCK_50),
        .FPGA_RESET_N (FPGA_RESET_N),
        .SW           (SW),
        .KEY          (KEY),
        .LEDR         (LEDR),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3),
        .HEX4         (HEX4),
        .HEX5         (HEX5),
        .imem_bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc_i(input logic [3:0] op2, input logic [3:0] op1,
                                          input logic [15:0] imm, input logic [3:0] a,
                                          input logic [3:0] b);
        return {op2, op1, imm, a, b};
    endfunction

    function automatic logic [31:0] enc_r(input logic [3:0] op2, input logic [3:0] c,
                                          input logic [3:0] a, input logic [3:0] b);
        return {op2, 4'hF, 12'h000, c, a, b};
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0x%08h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
            end
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        imem[addr[9:2]] = w;
    endtask

    task automatic hold_reset();
        @(negedge CLOCK_50);
        FPGA_RESET_N = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge CLOCK_50);
        FPGA_RESET_N = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic check_hex_all(input logic [31:0] h0);
        push("hex0", h0);
        push("hex1", SEG_0);
        push("hex2", SEG_0);
        push("hex3", SEG_0);
        push("hex4", SEG_0);
        push("hex5", SEG_0);
        check({25'd0, HEX0});
        check({25'd0, HEX1});
        check({25'd0, HEX2});
        check({25'd0, HEX3});
        check({25'd0, HEX4});
        check({25'd0, HEX5});
    endtask

    initial begin
        FPGA_RESET_N = 1'b0;
        SW           = 10'h2AA;
        KEY          = 4'hA;
        clear_imem();
        repeat (2) @(negedge CLOCK_50);

        // Reset state
        push("rst_pc", 32'h0000_0040);
        check(bus.pcOut);
        push("rst_ledr", 32'h0000_0000);
        check({22'd0, LEDR});
        check_hex_all(SEG_0);

        // Straight-line I/O writes
        hold_reset();
        clear_imem();
        put(32'h40, enc_i(4'hF, 4'hB, 16'hF000, 4'h0, 4'h1));
        put(32'h44, enc_i(4'h3, 4'hB, 16'h000F, 4'h0, 4'h2));
        put(32'h48, enc_i(4'h0, 4'h8, 16'h0000, 4'h2, 4'h1));
        put(32'h4C, enc_i(4'h0, 4'h8, 16'h0004, 4'h2, 4'h1));
        put(32'h50, HALT);
        release_reset();
        step(6);
        check_hex_all(SEG_F);
        push("line_ledr", 32'h0000_000F);
        check({22'd0, LEDR});
        push("line_pc", 32'h0000_0050);
        check(bus.pcOut);

        // Switch/key reads, data memory store/load, ignored I/O store, aliasing
        hold_reset();
        clear_imem();
        put(32'h40, enc_i(4'hF, 4'hB, 16'hF000, 4'h0, 4'h1));
        put(32'h44, enc_i(4'h0, 4'h9, 16'h0014, 4'h1, 4'h3));
        put(32'h48, enc_i(4'h0, 4'h9, 16'h0010, 4'h1, 4'h4));
        put(32'h4C, enc_i(4'h0, 4'h8, 16'h0000, 4'h3, 4'h0));
        put(32'h50, enc_i(4'h0, 4'h8, 16'h0004, 4'h4, 4'h0));
        put(32'h54, enc_i(4'h0, 4'h9, 16'h0000, 4'h0, 4'h5));
        put(32'h58, enc_i(4'h0, 4'h9, 16'h0004, 4'h0, 4'h6));
        put(32'h5C, enc_i(4'h0, 4'h8, 16'h0010, 4'h3, 4'h1));
        put(32'h60, enc_i(4'h0, 4'h9, 16'h0010, 4'h1, 4'h7));
        put(32'h64, enc_i(4'h0, 4'h9, 16'h2000, 4'h0, 4'h8));
        put(32'h68, HALT);
        release_reset();
        step(13);
        push("sw_read_r3", 32'h0000_02AA);
        check(dut.rf_r[3]);
        push("key_read_r4", 32'h0000_000A);
        check(dut.rf_r[4]);
        push("dmem_w0_r5", 32'h0000_02AA);
        check(dut.rf_r[5]);
        push("dmem_w1_r6", 32'h0000_000A);
        check(dut.rf_r[6]);
        push("key_store_ignored_r7", 32'h0000_000A);
        check(dut.rf_r[7]);
        push("dmem_alias_r8", 32'h0000_02AA);
        check(dut.rf_r[8]);
        push("io_pc", 32'h0000_0068);
        check(bus.pcOut);

        // Halt loop holds PC and state; then asynchronous reset mid-run
        hold_reset();
        clear_imem();
        put(32'h40, enc_i(4'hF, 4'hB, 16'hF000, 4'h0, 4'h1));
        put(32'h44, enc_i(4'h3, 4'hB, 16'h0155, 4'h0, 4'h2));
        put(32'h48, enc_i(4'h0, 4'h8, 16'h0004, 4'h2, 4'h1));
        put(32'h64, HALT);
        put(32'h68, enc_i(4'h0, 4'h8, 16'h0000, 4'h2, 4'h1));
        release_reset();
        step(10);
        push("halt_pc_a", 32'h0000_0064);
        check(bus.pcOut);
        step(6);
        push("halt_pc_b", 32'h0000_0064);
        check(bus.pcOut);
        push("halt_ledr", 32'h0000_0155);
        check({22'd0, LEDR});
        push("halt_hex0", SEG_0);
        check({25'd0, HEX0});
        push("halt_r2", 32'h0000_0155);
        check(dut.rf_r[2]);
        #2;
        FPGA_RESET_N = 1'b0;
        #1;
        push("midrst_pc", 32'h0000_0040);
        check(bus.pcOut);
        push("midrst_ledr", 32'h0000_0000);
        check({22'd0, LEDR});
        push("midrst_r2", 32'h0000_0000);
        check(dut.rf_r[2]);

        // ALU corners
        hold_reset();
        clear_imem();
        put(32'h40, enc_i(4'h0, 4'hB, 16'hFFFF, 4'h0, 4'h1));
        put(32'h44, enc_i(4'h0, 4'hB, 16'h0001, 4'h0, 4'h2));
        put(32'h48, enc_r(4'h0, 4'h2, 4'h1, 4'h3));
        put(32'h4C, enc_r(4'h1, 4'h2, 4'h0, 4'h4));
        put(32'h50, enc_r(4'h5, 4'h1, 4'h1, 4'h5));
        put(32'h54, enc_i(4'hF, 4'hB, 16'h1234, 4'h0, 4'h6));
        put(32'h58, enc_r(4'h4, 4'h1, 4'h6, 4'h7));
        put(32'h5C, enc_i(4'h2, 4'hB, 16'h00FF, 4'h1, 4'h8));
        put(32'h60, enc_i(4'h6, 4'hB, 16'h0000, 4'h0, 4'h9));
        put(32'h64, enc_r(4'h7, 4'h1, 4'h6, 4'hA));
        put(32'h68, enc_i(4'h8, 4'hB, 16'h0005, 4'h0, 4'h1));
        put(32'h6C, enc_i(4'h0, 4'h5, 16'hFFFF, 4'h1, 4'h1));
        put(32'h70, enc_r(4'h9, 4'h2, 4'h2, 4'h2));
        put(32'h74, HALT);
        release_reset();
        step(15);
        push("addi_sext_r1", 32'hFFFF_FFFF);
        check(dut.rf_r[1]);
        push("bad_op2_r2", 32'h0000_0001);
        check(dut.rf_r[2]);
        push("add_wrap_r3", 32'h0000_0000);
        check(dut.rf_r[3]);
        push("sub_wrap_r4", 32'hFFFF_FFFF);
        check(dut.rf_r[4]);
        push("nand_r5", 32'h0000_0000);
        check(dut.rf_r[5]);
        push("mvhi_r6", 32'h1234_0000);
        check(dut.rf_r[6]);
        push("xor_r7", 32'hEDCB_FFFF);
        check(dut.rf_r[7]);
        push("andi_r8", 32'h0000_00FF);
        check(dut.rf_r[8]);
        push("nori_r9", 32'hFFFF_FFFF);
        check(dut.rf_r[9]);
        push("xnor_r10", 32'h1234_0000);
        check(dut.rf_r[10]);
        push("alu_pc", 32'h0000_0074);
        check(bus.pcOut);

        // Branches
        hold_reset();
        clear_imem();
        put(32'h40, enc_i(4'h0, 4'hB, 16'h0005, 4'h0, 4'h1));
        put(32'h44, enc_i(4'h0, 4'hB, 16'h0005, 4'h0, 4'h2));
        put(32'h48, enc_i(4'h0, 4'h0, 16'h0002, 4'h1, 4'h2));
        put(32'h4C, enc_i(4'h0, 4'hB, 16'h0001, 4'h0, 4'h9));
        put(32'h50, enc_i(4'h0, 4'hB, 16'h0001, 4'h0, 4'h9));
        put(32'h54, enc_i(4'h1, 4'h0, 16'h0003, 4'h1, 4'h2));
        put(32'h58, enc_i(4'h0, 4'hB, 16'h0007, 4'h0, 4'h3));
        put(32'h5C, enc_i(4'h0, 4'h0, 16'h0004, 4'h1, 4'h3));
        put(32'h60, enc_i(4'h1, 4'h0, 16'h0001, 4'h1, 4'h3));
        put(32'h64, enc_i(4'h0, 4'hB, 16'h0001, 4'h0, 4'h9));
        put(32'h68, enc_i(4'h3, 4'hB, 16'h0080, 4'h0, 4'h4));
        put(32'h6C, HALT);
        release_reset();
        step(3);
        push("beq_taken_pc", 32'h0000_0054);
        check(bus.pcOut);
        step(1);
        push("bne_not_taken_pc", 32'h0000_0058);
        check(bus.pcOut);
        step(2);
        push("beq_not_taken_pc", 32'h0000_0060);
        check(bus.pcOut);
        step(1);
        push("bne_taken_pc", 32'h0000_0068);
        check(bus.pcOut);
        step(4);
        push("br_halt_pc", 32'h0000_006C);
        check(bus.pcOut);
        push("skipped_r9", 32'h0000_0000);
        check(dut.rf_r[9]);
        push("branch_r3", 32'h0000_0007);
        check(dut.rf_r[3]);

        // JAL at 0x50
        hold_reset();
        clear_imem();
        put(32'h40, enc_i(4'h3, 4'hB, 16'h0080, 4'h0, 4'h4));
        put(32'h50, enc_i(4'h0, 4'hA, 16'h0001, 4'h4, 4'h5));
        put(32'h84, HALT);
        release_reset();
        step(5);
        push("jal_pc", 32'h0000_0084);
        check(bus.pcOut);
        push("jal_link_r5", 32'h0000_0054);
        check(dut.rf_r[5]);
        step(3);
        push("jal_halt_pc", 32'h0000_0084);
        check(bus.pcOut);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
